rom_streamer: RTL

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_stream_pkg.sv | 14 +
 rtl/rom_streamer.sv | 107 ++++++++++
 2 files changed

// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM burst streamer: FSM state encoding and
// default geometry of the external ROM.
package rom_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/rom_streamer.sv
// Streams a burst of consecutive words from an external combinational ROM onto
// a valid/ready interface, with a one-cycle done pulse after the last beat.
module rom_streamer
  import rom_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = 0;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_TWO  = 2;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    m_valid_q;
  logic                    m_last_q;

  logic                    accept_start;
  logic                    handshake;
  logic                    final_hs;
  logic [ADDR_WIDTH-1:0]   rom_addr_d;

  assign accept_start = (state_q == IDLE) && start && (length != CNT_ZERO);
  assign handshake    = (state_q == STREAM) && m_valid_q && m_ready;
  assign final_hs     = handshake && (count_q == CNT_ONE);

  // The ROM is combinational, so the address must already point at the word
  // that m_data will capture on this same edge.
  always_comb begin
    rom_addr_d = cur_addr_q;
    if (accept_start) begin
      rom_addr_d = base_addr;
    end else if (handshake) begin
      rom_addr_d = cur_addr_q + ADDR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      count_q    <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_start) begin
            count_q    <= length;
            cur_addr_q <= rom_addr_d;
            m_data_q   <= rom_data;
            m_valid_q  <= 1'b1;
            m_last_q   <= (length == CNT_ONE);
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (handshake) begin
            count_q    <= count_q - CNT_ONE;
            cur_addr_q <= rom_addr_d;
            if (final_hs) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              state_q   <= DONE;
            end else begin
              m_data_q <= rom_data;
              m_last_q <= (count_q == CNT_TWO);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr = rom_addr_d;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
